// File: rtl/snn_spi_cfg_regfile_pkg.sv
// Shared SPI config-frame constants and FSM encoding for the spiking-neuron
// configuration register file.
package snn_spi_cfg_regfile_pkg;

  localparam int SPI_FRAME_BITS = 16;
  localparam int SPI_ADDR_BITS  = 7;
  localparam int SPI_CMD_BITS   = 8;
  localparam int SPI_RW_BIT     = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } spi_state_e;

  function automatic logic addr_in_range(input logic [SPI_ADDR_BITS-1:0] addr,
                                         input int num_regs);
    return int'(addr) < num_regs;
  endfunction

endpackage

// File: rtl/snn_spi_cfg_regfile_sync.sv
// Pad synchronisers for the SPI slave: 2-FF sync on sclk/cs_n/mosi plus a
// history flop on sclk for single-clk rise/fall strobes.
module snn_spi_cfg_regfile_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n_s,
  output logic mosi_s
);

  logic [2:0] sclk_q;
  logic [1:0] cs_n_q;
  logic [1:0] mosi_q;

  // Reset to the idle bus condition so no false edge appears on release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 3'b000;
      cs_n_q <= 2'b11;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_n_q <= {cs_n_q[0], cs_n};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_n_s    = cs_n_q[1];
  assign mosi_s    = mosi_q[1];

endmodule

// File: rtl/snn_spi_cfg_regfile.sv
// SPI mode-0 slave register file feeding the neuron core configuration bus.
// state   | meaning
// IDLE    | cs_n high, waiting for a frame
// CMD     | shifting RW + address (rises 1..8)
// DATA    | shifting write data or driving read data (rises 9..16)
// DONE    | frame complete, extra sclk edges ignored until cs_n rises
module snn_spi_cfg_regfile
  import snn_spi_cfg_regfile_pkg::*;
#(
  parameter int          NUM_REGS  = 16,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic [NUM_REGS*8-1:0] cfg_flat,
  output logic                  wr_pulse,
  output logic [6:0]            wr_addr
);

  localparam int CNT_W = 5;

  logic sclk_rise, sclk_fall, cs_n_s, mosi_s;

  snn_spi_cfg_regfile_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_n_s    (cs_n_s),
    .mosi_s    (mosi_s)
  );

  spi_state_e               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [6:0]               rx_q, rx_d;
  logic [7:0]               rx_next;
  logic [7:0]               tx_q, tx_d;
  logic                     rw_q, rw_d;
  logic [SPI_ADDR_BITS-1:0] addr_q, addr_d;
  logic                     wr_en;
  logic [7:0]               rd_val;
  logic [7:0]               regs_q [NUM_REGS];
  logic                     miso_q, wr_pulse_q;
  logic [6:0]               wr_addr_q;

  assign rx_next = {rx_q, mosi_s};

  // Addresses outside the populated range read back as zero
  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rx_next[6:0] == 7'(i)) rd_val = regs_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wr_en   = 1'b0;
    if (cs_n_s) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          cnt_d   = '0;
        end
        ST_CMD: if (sclk_rise) begin
          rx_d  = rx_next[6:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(SPI_CMD_BITS - 1)) begin
            state_d = ST_DATA;
            rw_d    = rx_next[SPI_RW_BIT - SPI_CMD_BITS];
            addr_d  = rx_next[6:0];
            tx_d    = rx_next[SPI_RW_BIT - SPI_CMD_BITS] ? 8'h00 : rd_val;
          end
        end
        ST_DATA: begin
          if (sclk_rise) begin
            rx_d  = rx_next[6:0];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(SPI_FRAME_BITS - 1)) begin
              state_d = ST_DONE;
              wr_en   = rw_q && addr_in_range(addr_q, NUM_REGS);
            end
          // bit 7 must survive the fall right after the 8th rise
          end else if (sclk_fall && cnt_q > CNT_W'(SPI_CMD_BITS)) begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      miso_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      miso_q     <= (state_q == ST_DATA && !rw_q) ? tx_q[7] : 1'b0;
      wr_pulse_q <= wr_en;
      if (wr_en) wr_addr_q <= addr_q;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && addr_q == 7'(i)) regs_q[i] <= rx_next;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign cfg_flat[8*g +: 8] = regs_q[g];
  end

  assign miso     = miso_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;

endmodule
